// File: rtl/pe_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding, cmd_swap bit positions
// and the bit-width helper used for select buses.
package GLOBAL_PARAM;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        SWITCH,
        START,
        RUN,
        DRAIN
    } sched_state_t;

    localparam int unsigned SWAP_D = 0;
    localparam int unsigned SWAP_P = 1;
    localparam int unsigned SWAP_I = 2;
    localparam int unsigned SWAP_A = 3;

    // Bits needed to encode 0..n-1; never narrower than one bit.
    function automatic int unsigned bw(input int unsigned n);
        return (n <= 1) ? 1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/pe_done_collect.sv
// Accumulates per-PE completion pulses and reports when every masked PE has
// finished; the current cycle's pulses count toward all_done immediately.
module pe_done_collect
    import GLOBAL_PARAM::*;
#(
    parameter int unsigned PE_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [PE_NUM-1:0] mask,
    input  logic [PE_NUM-1:0] done,
    output logic              all_done
);

    logic [PE_NUM-1:0] seen;
    logic [PE_NUM-1:0] hit;

    assign hit      = done & mask;
    assign all_done = ((seen | hit) == mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen <= '0;
        end else if (clear) begin
            seen <= '0;
        end else begin
            seen <= seen | hit;
        end
    end

endmodule

// File: rtl/pe_sched.sv
// PE array scheduler: accepts a compute command, waits for shadow loads,
// flips ping-pong banks, starts the masked PEs, collects completion, drains.
module pe_sched
    import GLOBAL_PARAM::*;
#(
    parameter int unsigned PE_NUM = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_mode,
    input  logic [7:0]                  cmd_idx_cnt,
    input  logic [7:0]                  cmd_trip_cnt,
    input  logic                        cmd_is_new,
    input  logic [3:0]                  cmd_pad_code,
    input  logic                        cmd_cut_y,
    input  logic [PE_NUM-1:0]           cmd_pe_mask,
    input  logic [3:0]                  cmd_swap,
    input  logic                        cmd_swap_b,
    input  logic                        cmd_drain,
    input  logic [PE_NUM-1:0]           load_ready,
    output logic [PE_NUM-1:0]           load_ack,
    output logic [PE_NUM-1:0]           switch_d,
    output logic [PE_NUM-1:0]           switch_p,
    output logic [PE_NUM-1:0]           switch_i,
    output logic [PE_NUM-1:0]           switch_a,
    output logic                        switch_b,
    output logic [PE_NUM-1:0]           start,
    input  logic [PE_NUM-1:0]           done,
    output logic [2:0]                  mode,
    output logic [7:0]                  idx_cnt,
    output logic [7:0]                  trip_cnt,
    output logic                        is_new,
    output logic [3:0]                  pad_code,
    output logic                        cut_y,
    output logic [bw(PE_NUM/4)-1:0]     rd_sel,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic                        busy
);

    localparam int unsigned RD_W = bw(PE_NUM / 4);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(PE_NUM / 4 - 1);

    sched_state_t      state;
    logic [PE_NUM-1:0] mask_q;
    logic [3:0]        swap_q;
    logic              swap_b_q;
    logic              drain_q;
    logic              all_done;
    logic [PE_NUM-1:0] run_done;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign run_done  = (state == RUN) ? done : '0;

    pe_done_collect #(
        .PE_NUM (PE_NUM)
    ) u_done_collect (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == START),
        .mask     (mask_q),
        .done     (run_done),
        .all_done (all_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mask_q   <= '0;
            swap_q   <= '0;
            swap_b_q <= 1'b0;
            drain_q  <= 1'b0;
            mode     <= '0;
            idx_cnt  <= '0;
            trip_cnt <= '0;
            is_new   <= 1'b0;
            pad_code <= '0;
            cut_y    <= 1'b0;
            load_ack <= '0;
            start    <= '0;
            switch_d <= '0;
            switch_p <= '0;
            switch_i <= '0;
            switch_a <= '0;
            switch_b <= 1'b0;
            rd_sel   <= '0;
            rd_valid <= 1'b0;
        end else begin
            load_ack <= '0;
            start    <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mask_q   <= cmd_pe_mask;
                        swap_q   <= cmd_swap;
                        swap_b_q <= cmd_swap_b;
                        drain_q  <= cmd_drain;
                        mode     <= cmd_mode;
                        idx_cnt  <= cmd_idx_cnt;
                        trip_cnt <= cmd_trip_cnt;
                        is_new   <= cmd_is_new;
                        pad_code <= cmd_pad_code;
                        cut_y    <= cmd_cut_y;
                        // An empty mask is consumed without touching any PE.
                        state    <= (cmd_pe_mask == '0) ? IDLE : WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if ((load_ready & mask_q) == mask_q) begin
                        switch_d <= switch_d ^ (swap_q[SWAP_D] ? mask_q : '0);
                        switch_p <= switch_p ^ (swap_q[SWAP_P] ? mask_q : '0);
                        switch_i <= switch_i ^ (swap_q[SWAP_I] ? mask_q : '0);
                        switch_a <= switch_a ^ (swap_q[SWAP_A] ? mask_q : '0);
                        switch_b <= switch_b ^ swap_b_q;
                        load_ack <= mask_q;
                        state    <= SWITCH;
                    end
                end
                SWITCH: begin
                    start <= mask_q;
                    state <= START;
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (all_done) begin
                        rd_valid <= drain_q;
                        state    <= drain_q ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        if (rd_sel == RD_LAST) begin
                            rd_sel   <= '0;
                            rd_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_sel <= rd_sel + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: a command table with hand-computed bank states
// plus hand-written timing sequences for load stall, drain, reset and done.
module tb_pe_sched;

    localparam int unsigned PE_NUM = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_mode;
    logic [7:0]        cmd_idx_cnt;
    logic [7:0]        cmd_trip_cnt;
    logic              cmd_is_new;
    logic [3:0]        cmd_pad_code;
    logic              cmd_cut_y;
    logic [PE_NUM-1:0] cmd_pe_mask;
    logic [3:0]        cmd_swap;
    logic              cmd_swap_b;
    logic              cmd_drain;
    logic [PE_NUM-1:0] load_ready;
    logic [PE_NUM-1:0] load_ack;
    logic [PE_NUM-1:0] switch_d, switch_p, switch_i, switch_a;
    logic              switch_b;
    logic [PE_NUM-1:0] start;
    logic [PE_NUM-1:0] done;
    logic [2:0]        mode;
    logic [7:0]        idx_cnt;
    logic [7:0]        trip_cnt;
    logic              is_new;
    logic [3:0]        pad_code;
    logic              cut_y;
    logic [2:0]        rd_sel;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;

    always #5 clk = ~clk;

    pe_sched #(.PE_NUM(PE_NUM)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_idx_cnt(cmd_idx_cnt), .cmd_trip_cnt(cmd_trip_cnt),
        .cmd_is_new(cmd_is_new), .cmd_pad_code(cmd_pad_code), .cmd_cut_y(cmd_cut_y),
        .cmd_pe_mask(cmd_pe_mask), .cmd_swap(cmd_swap), .cmd_swap_b(cmd_swap_b),
        .cmd_drain(cmd_drain),
        .load_ready(load_ready), .load_ack(load_ack),
        .switch_d(switch_d), .switch_p(switch_p), .switch_i(switch_i),
        .switch_a(switch_a), .switch_b(switch_b),
        .start(start), .done(done),
        .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt), .is_new(is_new),
        .pad_code(pad_code), .cut_y(cut_y),
        .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy)
    );

    typedef struct {
        logic [31:0] mask;
        logic [3:0]  swap;
        logic        sb;
        logic        drain;
        logic [2:0]  mode;
        logic [7:0]  idx;
        logic [7:0]  trip;
        logic [3:0]  pad;
        logic [31:0] e_d, e_p, e_i, e_a;
        logic        e_b;
    } vec_t;

    vec_t tbl[5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] m, input logic [3:0] sw, input logic sb, input logic dr);
        @(negedge clk);
        chk("send_cmd_ready", {31'b0, cmd_ready}, 1);
        cmd_valid   = 1'b1;
        cmd_pe_mask = m;
        cmd_swap    = sw;
        cmd_swap_b  = sb;
        cmd_drain   = dr;
        @(negedge clk);
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_start();
        for (int k = 0; k < 50 && start == '0; k++) @(negedge clk);
        chk("start_seen", {31'b0, |start}, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int acks = 0;
        int starts = 0;
        int rds = 0;
        int start_cyc = -10;
        bit fin = 1'b0;
        @(negedge clk);
        chk("vec_cmd_ready", {31'b0, cmd_ready}, 1);
        cmd_valid    = 1'b1;
        cmd_pe_mask  = v.mask;
        cmd_swap     = v.swap;
        cmd_swap_b   = v.sb;
        cmd_drain    = v.drain;
        cmd_mode     = v.mode;
        cmd_idx_cnt  = v.idx;
        cmd_trip_cnt = v.trip;
        cmd_is_new   = v.idx[0];
        cmd_pad_code = v.pad;
        cmd_cut_y    = v.trip[0];
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("vec_fields", {7'b0, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y},
            {7'b0, v.mode, v.idx, v.trip, v.idx[0], v.pad, v.trip[0]});
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            done = (cyc == start_cyc + 2) ? v.mask : '0;
            if (load_ack != '0) begin
                acks++;
                chk("vec_ack", load_ack, v.mask);
            end
            if (start != '0) begin
                starts++;
                start_cyc = cyc;
                chk("vec_start_latency", cyc, 3);
                chk("vec_start", start, v.mask);
            end
            if (rd_valid) begin
                chk("vec_rd_sel", {29'b0, rd_sel}, rds);
                rds++;
            end
            if (!busy) fin = 1'b1;
            else @(negedge clk);
        end
        done = '0;
        chk("vec_idle", {31'b0, busy}, 0);
        chk("vec_acks", acks, (v.mask != 0) ? 1 : 0);
        chk("vec_starts", starts, (v.mask != 0) ? 1 : 0);
        chk("vec_drain_beats", rds, v.drain ? 8 : 0);
        chk("vec_switch_d", switch_d, v.e_d);
        chk("vec_switch_p", switch_p, v.e_p);
        chk("vec_switch_i", switch_i, v.e_i);
        chk("vec_switch_a", switch_a, v.e_a);
        chk("vec_switch_b", {31'b0, switch_b}, {31'b0, v.e_b});
    endtask

    initial begin
        int exp_sel;
        int hs;
        bit phase;

        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_idx_cnt = '0; cmd_trip_cnt = '0;
        cmd_is_new = 1'b0; cmd_pad_code = '0; cmd_cut_y = 1'b0; cmd_pe_mask = '0;
        cmd_swap = '0; cmd_swap_b = 1'b0; cmd_drain = 1'b0; load_ready = '0;
        done = '0; rd_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_start", start, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_switch_d", switch_d, 0);
        chk("rst_rd", {28'b0, rd_valid, rd_sel}, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Completion staggered at +5,+6,+7,+9 cycles after start.
        load_ready = '1;
        send(32'h0000_000F, 4'b0001, 1'b0, 1'b0);
        chk("t1_wait_no_start", start, 0);
        @(negedge clk);
        chk("t1_ack", load_ack, 32'hF);
        chk("t1_switch_d", switch_d, 32'hF);
        chk("t1_switch_p", switch_p, 0);
        @(negedge clk);
        chk("t1_start", start, 32'hF);
        chk("t1_ack_gone", load_ack, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) chk("t1_start_once", start, 0);
            if (k < 10) chk("t1_busy", {31'b0, busy}, 1);
            else chk("t1_idle_after_pe3", {31'b0, busy}, 0);
            done = (k == 5) ? 32'h1 : (k == 6) ? 32'h2 : (k == 7) ? 32'h4 : (k == 9) ? 32'h8 : 32'h0;
        end
        done = '0;

        tbl[0] = '{32'h0000_00FF, 4'b0011, 1'b1, 1'b0, 3'd1, 8'h12, 8'h34, 4'h5,
                   32'h0000_00F0, 32'h0000_00FF, 32'h0, 32'h0, 1'b1};
        tbl[1] = '{32'h0000_0000, 4'b1111, 1'b1, 1'b0, 3'd2, 8'hA5, 8'h5A, 4'hA,
                   32'h0000_00F0, 32'h0000_00FF, 32'h0, 32'h0, 1'b1};
        tbl[2] = '{32'hFFFF_0000, 4'b1100, 1'b1, 1'b0, 3'd7, 8'hFF, 8'h01, 4'hF,
                   32'h0000_00F0, 32'h0000_00FF, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0};
        tbl[3] = '{32'h8000_0001, 4'b1010, 1'b0, 1'b0, 3'd4, 8'h00, 8'hFE, 4'h0,
                   32'h0000_00F0, 32'h8000_00FE, 32'hFFFF_0000, 32'h7FFF_0001, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 4'b0100, 1'b0, 1'b1, 3'd3, 8'h81, 8'h18, 4'h9,
                   32'h0000_00F0, 32'h8000_00FE, 32'h0000_FFFF, 32'h7FFF_0001, 1'b0};
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Load stall: PE7 missing and bits outside the mask set must not release it.
        load_ready = 32'hFFFF_FF7F;
        send(32'h0000_00FF, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("t2_no_ack", load_ack, 0);
            chk("t2_no_start", start, 0);
            @(negedge clk);
        end
        chk("t2_still_busy", {31'b0, busy}, 1);
        load_ready = 32'h0000_00FF;
        @(negedge clk);
        chk("t2_ack", load_ack, 32'hFF);
        @(negedge clk);
        chk("t2_ack_single", load_ack, 0);
        chk("t2_start", start, 32'hFF);
        chk("t2_switch_unchanged", switch_p, 32'h8000_00FE);
        @(negedge clk);
        done = 32'hFF;
        @(negedge clk);
        done = '0;
        chk("t2_idle", {31'b0, busy}, 0);

        // Drain with rd_ready toggling 1,0,1,...
        load_ready = '1;
        rd_ready   = 1'b0;
        send(32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1);
        wait_start();
        @(negedge clk);
        done = '1;
        @(negedge clk);
        done = '0;
        chk("t3_rd_valid", {31'b0, rd_valid}, 1);
        exp_sel = 0;
        hs      = 0;
        phase   = 1'b1;
        for (int k = 0; k < 40 && rd_valid; k++) begin
            chk("t3_rd_sel", {29'b0, rd_sel}, exp_sel);
            rd_ready = phase;
            if (phase) begin
                hs++;
                exp_sel = (exp_sel + 1) % 8;
            end
            phase = !phase;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("t3_handshakes", hs, 8);
        chk("t3_idle", {31'b0, busy}, 0);
        chk("t3_rd_sel_zero", {29'b0, rd_sel}, 0);

        // Reset cuts an in-flight ack, and again in RUN after half the PEs finish.
        send(32'h0000_000F, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_ack_before_rst", load_ack, 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("t5_ack_cut", load_ack, 0);
        chk("t5_switch_d_cut", switch_d, 0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h0000_000F, 4'b0011, 1'b1, 1'b1);
        wait_start();
        @(negedge clk);
        done = 32'h3;
        @(negedge clk);
        done = '0;
        chk("t5_in_run", {31'b0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("t5_start", start, 0);
        chk("t5_switch_p", switch_p, 0);
        chk("t5_switch_ia", switch_i | switch_a, 0);
        chk("t5_switch_b", {31'b0, switch_b}, 0);
        chk("t5_rd", {28'b0, rd_valid, rd_sel}, 0);
        chk("t5_fields", {7'b0, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h0000_000F, 4'b0000, 1'b0, 1'b0);
        wait_start();
        @(negedge clk);
        done = 32'h3;
        @(negedge clk);
        done = '0;
        chk("t5_not_early", {31'b0, busy}, 1);
        @(negedge clk);
        done = 32'hC;
        @(negedge clk);
        done = '0;
        chk("t5_new_cmd_done", {31'b0, busy}, 0);

        // switch_b ping-pong; duplicate and unmasked done must not end RUN.
        send(32'h0000_0003, 4'b0000, 1'b1, 1'b0);
        wait_start();
        @(negedge clk);
        done = 32'h1;
        @(negedge clk);
        done = 32'h1;
        @(negedge clk);
        chk("t6_dup_done", {31'b0, busy}, 1);
        done = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("t6_unmasked_done", {31'b0, busy}, 1);
        done = 32'h2;
        @(negedge clk);
        done = '0;
        chk("t6_idle", {31'b0, busy}, 0);
        chk("t6_switch_b_1", {31'b0, switch_b}, 1);
        send(32'h0000_0003, 4'b0000, 1'b1, 1'b0);
        wait_start();
        @(negedge clk);
        done = 32'h3;
        @(negedge clk);
        done = '0;
        chk("t6_idle2", {31'b0, busy}, 0);
        chk("t6_switch_b_0", {31'b0, switch_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
